// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: turns load/store controls into a
// req/ack bus transaction, formats store lanes and aligns/extends load data.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_rd,
  output logic        mem_regwrite,
  output logic        mem_memtoreg,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic [4:0]  mem_rd,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        mem_bus_error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [31:0] r_data;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_bus_err;
  logic        r_supp;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_load;

  logic        w_access;
  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_issue;
  logic        w_ack_hit;
  logic        w_tmo;
  logic [7:0]  w_b8;
  logic [15:0] w_h16;
  logic [31:0] w_ld;

  assign w_access = ex_memread | ex_memwrite;
  assign w_word   = ex_size[1];
  assign w_half   = (ex_size == 2'b01);
  assign w_mis    = (w_half & ex_alu_result[0]) |
                    (w_word & (|ex_alu_result[1:0]));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_write_data;
    unique case (1'b1)
      (ex_size == 2'b00): begin
        w_be    = 4'b0001 << ex_alu_result[1:0];
        w_wdata = {4{ex_write_data[7:0]}};
      end
      w_half: begin
        w_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{ex_write_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ex_write_data;
      end
    endcase
  end

  // lane select uses the offset latched at issue, not the live inputs
  assign w_b8  = dmem_rdata[{r_off, 3'b000} +: 8];
  assign w_h16 = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_ld = dmem_rdata;
    unique case (1'b1)
      (r_size == 2'b00): w_ld = {{24{~r_uns & w_b8[7]}}, w_b8};
      (r_size == 2'b01): w_ld = {{16{~r_uns & w_h16[15]}}, w_h16};
      default:           w_ld = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ack_hit   = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access && !w_mis) begin
          w_issue     = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == TMO_M1) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_bus_err <= 1'b0;
      r_supp    <= 1'b0;
      r_off     <= '0;
      r_size    <= '0;
      r_uns     <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_bus_err <= w_tmo;
      if (w_issue) begin
        r_cnt   <= '0;
        r_req   <= 1'b1;
        r_we    <= ex_memwrite;
        r_addr  <= {ex_alu_result[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_off   <= ex_alu_result[1:0];
        r_size  <= ex_size;
        r_uns   <= ex_unsigned;
        r_load  <= ~ex_memwrite;
      end else if (w_ack_hit) begin
        r_req  <= 1'b0;
        r_data <= r_load ? w_ld : 32'd0;
      end else if (w_tmo) begin
        r_req  <= 1'b0;
        r_data <= '0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_tmo)                  r_supp <= 1'b1;
      else if (r_state == S_DONE) r_supp <= 1'b0;
    end
  end

  assign mem_stall      = ((r_state == S_IDLE) & w_access & ~w_mis) |
                          (r_state == S_BUSY);
  assign mem_misaligned = w_access & w_mis;
  assign mem_regwrite   = ex_regwrite & ~mem_misaligned &
                          ~((r_state == S_DONE) & r_supp);
  assign mem_memtoreg   = ex_memtoreg;
  assign mem_alu_result = ex_alu_result;
  assign mem_rd         = ex_rd;
  assign mem_read_data  = (r_state == S_DONE) ? r_data : 32'd0;
  assign mem_bus_error  = r_bus_err;
  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_be        = r_be;
  assign dmem_wdata     = r_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment,
// timeout and mid-transaction reset against hand-computed values.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [4:0]  ex_rd;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [4:0]  mem_rd;
  logic        mem_stall;
  logic        mem_misaligned;
  logic        mem_bus_error;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite),
    .ex_size(ex_size),
    .ex_unsigned(ex_unsigned),
    .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg),
    .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data),
    .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg),
    .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data),
    .mem_rd(mem_rd),
    .mem_stall(mem_stall),
    .mem_misaligned(mem_misaligned),
    .mem_bus_error(mem_bus_error),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    ex_memread    = rd;
    ex_memwrite   = wr;
    ex_size       = sz;
    ex_unsigned   = uns;
    ex_regwrite   = rd;
    ex_memtoreg   = rd;
    ex_alu_result = a;
    ex_write_data = wd;
    ex_rd         = 5'd7;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    ex_regwrite = 1'b0;
    dmem_ack    = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] rdat, input logic [31:0] exp);
    issue(1'b1, 1'b0, sz, uns, a, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = rdat;
    step();
    step();
    chk(tag, mem_read_data, exp);
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    dmem_rdata = 32'h0;
    idle();
    #12;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_berr", {31'd0, mem_bus_error}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    #1 rst = 1'b0;
    step();

    // non-memory passthrough
    ex_regwrite   = 1'b1;
    ex_alu_result = 32'h0000_1234;
    ex_rd         = 5'd9;
    #1;
    chk("nm_stall", {31'd0, mem_stall}, 32'd0);
    chk("nm_rdata", mem_read_data, 32'h0);
    chk("nm_alu", mem_alu_result, 32'h0000_1234);
    chk("nm_rd", {27'd0, mem_rd}, 32'd9);
    chk("nm_rw", {31'd0, mem_regwrite}, 32'd1);
    idle();
    step();

    // LW 0x100, ack on first BUSY cycle
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw_stall0", {31'd0, mem_stall}, 32'd1);
    chk("lw_req0", {31'd0, dmem_req}, 32'd0);
    step();
    chk("lw_req1", {31'd0, dmem_req}, 32'd1);
    chk("lw_stall1", {31'd0, mem_stall}, 32'd1);
    chk("lw_addr", dmem_addr, 32'h100);
    chk("lw_be", {28'd0, dmem_be}, 32'hF);
    chk("lw_we", {31'd0, dmem_we}, 32'd0);
    step();
    chk("lw_stall2", {31'd0, mem_stall}, 32'd0);
    chk("lw_req2", {31'd0, dmem_req}, 32'd0);
    chk("lw_data", mem_read_data, 32'hDEAD_BEEF);
    chk("lw_rw", {31'd0, mem_regwrite}, 32'd1);
    idle();
    step();

    load("lb", 2'b00, 1'b0, 32'h103, 32'h80FF_FF7F, 32'hFFFF_FF80);
    load("lbu", 2'b00, 1'b1, 32'h103, 32'h80FF_FF7F, 32'h0000_0080);
    load("lh", 2'b01, 1'b0, 32'h102, 32'h80FF_FF7F, 32'hFFFF_80FF);
    load("lhu0", 2'b01, 1'b1, 32'h100, 32'h1234_9ABC, 32'h0000_9ABC);
    load("lb1", 2'b00, 1'b0, 32'h101, 32'h1234_5678, 32'h0000_0056);

    // SB 0xAB at 0x201, ack on second BUSY cycle
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB);
    step();
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_be", {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h200);
    step();
    chk("sb_hold", {31'd0, dmem_req}, 32'd1);
    chk("sb_stall", {31'd0, mem_stall}, 32'd1);
    dmem_ack = 1'b1;
    step();
    chk("sb_done", {31'd0, mem_stall}, 32'd0);
    chk("sb_rdata", mem_read_data, 32'h0);
    idle();
    step();

    // SH 0x1234 at 0x202, then back-to-back LW
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234);
    dmem_ack = 1'b1;
    step();
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    chk("sh_addr", dmem_addr, 32'h200);
    step();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    dmem_rdata = 32'h0BAD_F00D;
    step();
    chk("b2b_stall", {31'd0, mem_stall}, 32'd1);
    chk("b2b_req0", {31'd0, dmem_req}, 32'd0);
    step();
    chk("b2b_req1", {31'd0, dmem_req}, 32'd1);
    chk("b2b_addr", dmem_addr, 32'h104);
    step();
    chk("b2b_data", mem_read_data, 32'h0BAD_F00D);
    idle();
    step();

    // misaligned LW at 0x102
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    #1;
    chk("mis_flag", {31'd0, mem_misaligned}, 32'd1);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    chk("mis_rw", {31'd0, mem_regwrite}, 32'd0);
    step();
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    idle();
    step();

    // timeout with TIMEOUT=4
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_req%0d", i), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("to_be%0d", i), {31'd0, mem_bus_error}, 32'd0);
    end
    step();
    chk("to_req_off", {31'd0, dmem_req}, 32'd0);
    chk("to_berr", {31'd0, mem_bus_error}, 32'd1);
    chk("to_data", mem_read_data, 32'h0);
    chk("to_rw", {31'd0, mem_regwrite}, 32'd0);
    chk("to_stall", {31'd0, mem_stall}, 32'd0);
    idle();
    step();
    chk("to_berr_off", {31'd0, mem_bus_error}, 32'd0);
    chk("to_idle_req", {31'd0, dmem_req}, 32'd0);

    // reset during BUSY, then the same LW completes
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    step();
    chk("rb_req", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rb_addr", dmem_addr, 32'h0);
    #1 rst = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    step();
    chk("ra_req", {31'd0, dmem_req}, 32'd1);
    chk("ra_addr", dmem_addr, 32'h400);
    step();
    chk("ra_data", mem_read_data, 32'h5555_AAAA);
    chk("ra_rw", {31'd0, mem_regwrite}, 32'd1);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
